// File: rtl/clint_mc.sv
// Multi-channel core-local interrupt controller: arbitrates ecall/ebreak/mret and
// masked level interrupts, sequences the trap CSR writes and redirects the PC.
module clint_mc #(
  parameter int INT_NUM = 8,
  parameter int DATA_W  = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [31:0]        inst_i,
  input  logic [DATA_W-1:0]  inst_addr_i,
  input  logic               jump_flag_i,
  input  logic [DATA_W-1:0]  jump_addr_i,
  input  logic [INT_NUM-1:0] int_req_i,
  input  logic [INT_NUM-1:0] int_mask_i,
  input  logic [DATA_W-1:0]  csr_mtvec_i,
  input  logic [DATA_W-1:0]  csr_mepc_i,
  input  logic [DATA_W-1:0]  csr_mstatus_i,
  output logic               clint_wen_o,
  output logic [11:0]        clint_waddr_o,
  output logic [DATA_W-1:0]  clint_wdata_o,
  output logic               hold_flag_o,
  output logic               int_flag_o,
  output logic [DATA_W-1:0]  int_addr_o,
  output logic               busy_o
);

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SAVE_EPC    = 3'd1,
    S_SAVE_CAUSE  = 3'd2,
    S_SAVE_STATUS = 3'd3,
    S_TRAP_JUMP   = 3'd4,
    S_MRET_STATUS = 3'd5,
    S_MRET_JUMP   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   epc_q, epc_d;
  logic [DATA_W-1:0]   cause_q, cause_d;
  logic [INT_NUM-1:0]  pend_s;
  logic [4:0]          win_idx_s;
  logic                is_ecall_s, is_ebreak_s, is_mret_s;
  logic                hold_s;
  logic [DATA_W-1:0]   mstatus_trap_s, mstatus_mret_s, trap_base_s;

  function automatic logic [4:0] lowest_set(input logic [INT_NUM-1:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = INT_NUM - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // Event decode and CSR value shaping
  always_comb begin
    is_ecall_s     = (inst_i == INST_ECALL);
    is_ebreak_s    = (inst_i == INST_EBREAK);
    is_mret_s      = (inst_i == INST_MRET);
    pend_s         = int_req_i & int_mask_i & {INT_NUM{csr_mstatus_i[3]}};
    win_idx_s      = lowest_set(pend_s);
    mstatus_trap_s = csr_mstatus_i;
    mstatus_trap_s[7] = csr_mstatus_i[3];
    mstatus_trap_s[3] = 1'b0;
    mstatus_mret_s = csr_mstatus_i;
    mstatus_mret_s[3] = csr_mstatus_i[7];
    mstatus_mret_s[7] = 1'b1;
    trap_base_s    = {csr_mtvec_i[DATA_W-1:2], 2'b00};
  end

  // State, epc and cause registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and Moore outputs; hold is also raised in the accepting IDLE cycle
  always_comb begin
    state_d       = state_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    clint_wen_o   = 1'b0;
    clint_waddr_o = 12'h000;
    clint_wdata_o = '0;
    int_flag_o    = 1'b0;
    int_addr_o    = '0;
    hold_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_ecall_s || is_ebreak_s) begin
          state_d = S_SAVE_EPC;
          epc_d   = inst_addr_i;
          cause_d = is_ecall_s ? DATA_W'(32'd11) : DATA_W'(32'd3);
          hold_s  = 1'b1;
        end else if (is_mret_s) begin
          state_d = S_MRET_STATUS;
          hold_s  = 1'b1;
        end else if (|pend_s) begin
          state_d = S_SAVE_EPC;
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
          cause_d = {1'b1, (DATA_W-1)'(5'd16 + win_idx_s)};
          hold_s  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SAVE_EPC: begin
        clint_wen_o   = 1'b1;
        clint_waddr_o = CSR_MEPC;
        clint_wdata_o = epc_q;
        hold_s        = 1'b1;
        state_d       = S_SAVE_CAUSE;
      end
      S_SAVE_CAUSE: begin
        clint_wen_o   = 1'b1;
        clint_waddr_o = CSR_MCAUSE;
        clint_wdata_o = cause_q;
        hold_s        = 1'b1;
        state_d       = S_SAVE_STATUS;
      end
      S_SAVE_STATUS: begin
        clint_wen_o   = 1'b1;
        clint_waddr_o = CSR_MSTATUS;
        clint_wdata_o = mstatus_trap_s;
        hold_s        = 1'b1;
        state_d       = S_TRAP_JUMP;
      end
      S_TRAP_JUMP: begin
        int_flag_o = 1'b1;
        hold_s     = 1'b1;
        state_d    = S_IDLE;
        // Vectored dispatch only for interrupts; the low cause bits hold 16+k
        if (csr_mtvec_i[1:0] == 2'b01 && cause_q[DATA_W-1]) begin
          int_addr_o = trap_base_s + {cause_q[DATA_W-3:0], 2'b00};
        end else begin
          int_addr_o = trap_base_s;
        end
      end
      S_MRET_STATUS: begin
        clint_wen_o   = 1'b1;
        clint_waddr_o = CSR_MSTATUS;
        clint_wdata_o = mstatus_mret_s;
        hold_s        = 1'b1;
        state_d       = S_MRET_JUMP;
      end
      S_MRET_JUMP: begin
        int_flag_o = 1'b1;
        int_addr_o = csr_mepc_i;
        hold_s     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign hold_flag_o = hold_s & rst_n_i;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_clint_mc.sv
// Directed self-checking bench for clint_mc: reset, trap/mret sequences,
// arbitration, masking, vectored dispatch and mid-sequence reset.
module tb_clint_mc;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst, inst_addr, jump_addr, mtvec, mepc, mstatus;
  logic        jump_flag;
  logic [7:0]  req, mask;
  logic        wen, hold, iflag, busy;
  logic [11:0] waddr;
  logic [31:0] wdata, iaddr;

  int errors = 0;
  int checks = 0;

  clint_mc #(.INT_NUM(8), .DATA_W(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .inst_i(inst), .inst_addr_i(inst_addr),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .int_req_i(req),
    .int_mask_i(mask), .csr_mtvec_i(mtvec), .csr_mepc_i(mepc),
    .csr_mstatus_i(mstatus), .clint_wen_o(wen), .clint_waddr_o(waddr),
    .clint_wdata_o(wdata), .hold_flag_o(hold), .int_flag_o(iflag),
    .int_addr_o(iaddr), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // {wen, waddr, wdata, hold, int_flag, int_addr, busy}
  function automatic logic [79:0] pack(input logic w, input logic [11:0] a,
      input logic [31:0] d, input logic h, input logic f, input logic [31:0] ia,
      input logic b);
    return {w, a, d, h, f, ia, b};
  endfunction

  function automatic logic [79:0] observed();
    return pack(wen, waddr, wdata, hold, iflag, iaddr, busy);
  endfunction

  // Expected outputs for cycle c (0 = accept cycle) of a trap sequence
  function automatic logic [79:0] trap_exp(input int c, input logic [31:0] epc,
      input logic [31:0] cause, input logic [31:0] st, input logic [31:0] tgt);
    case (c)
      0:       return pack(1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      1:       return pack(1'b1, 12'h341, epc,   1'b1, 1'b0, 32'h0, 1'b1);
      2:       return pack(1'b1, 12'h342, cause, 1'b1, 1'b0, 32'h0, 1'b1);
      3:       return pack(1'b1, 12'h300, st,    1'b1, 1'b0, 32'h0, 1'b1);
      4:       return pack(1'b0, 12'h000, 32'h0, 1'b1, 1'b1, tgt,   1'b1);
      default: return 80'h0;
    endcase
  endfunction

  task automatic clear_events();
    inst = NOP; req = 8'h00; jump_flag = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inst = ECALL; inst_addr = 32'h80; req = 8'hFF; mask = 8'hFF;
    jump_flag = 1'b0; jump_addr = 32'h0; mtvec = 32'h200; mepc = 32'h0;
    mstatus = 32'h8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (observed() !== 80'h0)
      begin errors++; $display("FAIL reset_outputs got %h exp %h", observed(), 80'h0); end
    inst = NOP;
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 5) clear_events();
      @(negedge clk);
      checks++;
      if (observed() !== trap_exp(c, 32'h80, 32'h8000_0010, 32'h80, 32'h200)) begin
        errors++;
        $display("FAIL reset_release c%0d got %h exp %h", c, observed(),
                 trap_exp(c, 32'h80, 32'h8000_0010, 32'h80, 32'h200));
      end
    end
  endtask

  task automatic test_ecall();
    @(posedge clk); #1;
    inst = ECALL; inst_addr = 32'h100; mtvec = 32'h200; mstatus = 32'h8;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 5) clear_events();
      @(negedge clk);
      checks++;
      if (observed() !== trap_exp(c, 32'h100, 32'd11, 32'h80, 32'h200)) begin
        errors++;
        $display("FAIL ecall c%0d got %h exp %h", c, observed(),
                 trap_exp(c, 32'h100, 32'd11, 32'h80, 32'h200));
      end
    end
  endtask

  task automatic test_async_vectored();
    @(posedge clk); #1;
    req = 8'b0000_1100; mask = 8'hFF; mstatus = 32'h8; mtvec = 32'h201;
    jump_flag = 1'b1; jump_addr = 32'h400; inst_addr = 32'h180;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 5) clear_events();
      @(negedge clk);
      checks++;
      if (observed() !== trap_exp(c, 32'h400, 32'h8000_0012, 32'h80, 32'h248)) begin
        errors++;
        $display("FAIL async_vec c%0d got %h exp %h", c, observed(),
                 trap_exp(c, 32'h400, 32'h8000_0012, 32'h80, 32'h248));
      end
    end
  endtask

  task automatic test_masking();
    @(posedge clk); #1;
    req = 8'h01; mask = 8'h00; mstatus = 32'h8;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin mask = 8'hFF; mstatus = 32'h0; end
      @(negedge clk);
      checks++;
      if (observed() !== 80'h0)
        begin errors++; $display("FAIL masking c%0d got %h exp %h", c, observed(), 80'h0); end
      @(posedge clk); #1;
    end
    clear_events(); mstatus = 32'h8;
  endtask

  task automatic test_mret();
    logic [79:0] ex [4];
    ex[0] = pack(1'b0, 12'h000, 32'h0,  1'b1, 1'b0, 32'h0,   1'b0);
    ex[1] = pack(1'b1, 12'h300, 32'h88, 1'b1, 1'b0, 32'h0,   1'b1);
    ex[2] = pack(1'b0, 12'h000, 32'h0,  1'b1, 1'b1, 32'h104, 1'b1);
    ex[3] = 80'h0;
    @(posedge clk); #1;
    inst = MRET; mepc = 32'h104; mstatus = 32'h80;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 3) clear_events();
      @(negedge clk);
      checks++;
      if (observed() !== ex[c])
        begin errors++; $display("FAIL mret c%0d got %h exp %h", c, observed(), ex[c]); end
    end
    mstatus = 32'h8;
  endtask

  task automatic test_simultaneous();
    @(posedge clk); #1;
    inst = ECALL; inst_addr = 32'h108; req = 8'hFF; mask = 8'hFF;
    mstatus = 32'h8; mtvec = 32'h201;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 5) clear_events();
      @(negedge clk);
      checks++;
      if (observed() !== trap_exp(c, 32'h108, 32'd11, 32'h80, 32'h200)) begin
        errors++;
        $display("FAIL simult c%0d got %h exp %h", c, observed(),
                 trap_exp(c, 32'h108, 32'd11, 32'h80, 32'h200));
      end
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    req = 8'h10; mask = 8'hFF; mstatus = 32'h8; mtvec = 32'h200; inst_addr = 32'h1C0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if (observed() !== trap_exp(c, 32'h1C0, 32'h8000_0014, 32'h80, 32'h200)) begin
        errors++;
        $display("FAIL pre_reset c%0d got %h exp %h", c, observed(),
                 trap_exp(c, 32'h1C0, 32'h8000_0014, 32'h80, 32'h200));
      end
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if (observed() !== 80'h0)
      begin errors++; $display("FAIL mid_reset got %h exp %h", observed(), 80'h0); end
    clear_events();
    @(posedge clk); #1; rst_n = 1'b1;
    inst = EBREAK; inst_addr = 32'h300; mtvec = 32'h200; mstatus = 32'h8;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == 5) clear_events();
      @(negedge clk);
      checks++;
      if (observed() !== trap_exp(c, 32'h300, 32'd3, 32'h80, 32'h200)) begin
        errors++;
        $display("FAIL ebreak c%0d got %h exp %h", c, observed(),
                 trap_exp(c, 32'h300, 32'd3, 32'h80, 32'h200));
      end
    end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_async_vectored();
    test_masking();
    test_mret();
    test_simultaneous();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clint_mc.md
# clint_mc

Multi-channel core-local interrupt controller for the RISC-V core. It is the parametrised successor of the single-flag CLINT. It arbitrates up to INT_NUM level-sensitive external interrupt lines plus the synchronous ecall, ebreak and mret instructions. Trap entry and exit run as sequenced CSR writes over the clint CSR port, then the controller redirects the PC, with optional vectored dispatch. It sits beside the execute stage: instruction inputs come from decode, CSR writes go to csr_reg, and hold and redirect go to ctrl.

## Interface

Parameters:
- INT_NUM, 8: number of external interrupt lines; legal range 1..16.
- DATA_W, 32: CSR and address width.

Ports:
- clk_i, in, 1: clock.
- rst_n_i, in, 1: reset. One clock; reset is asynchronous and active-low.
- inst_i, in, 32: instruction currently in decode.
- inst_addr_i, in, DATA_W: address of inst_i.
- jump_flag_i, in, 1: execute-stage jump in progress.
- jump_addr_i, in, DATA_W: execute-stage jump target.
- int_req_i, in, INT_NUM: level interrupt requests; bit 0 has the highest priority.
- int_mask_i, in, INT_NUM: per-line enable.
- csr_mtvec_i, in, DATA_W: current mtvec.
- csr_mepc_i, in, DATA_W: current mepc.
- csr_mstatus_i, in, DATA_W: current mstatus.
- clint_wen_o, out, 1: CSR write strobe.
- clint_waddr_o, out, 12: CSR write address.
- clint_wdata_o, out, DATA_W: CSR write data.
- hold_flag_o, out, 1: stall request to ctrl.
- int_flag_o, out, 1: one-cycle PC redirect strobe.
- int_addr_o, out, DATA_W: redirect target, valid while int_flag_o is high.
- busy_o, out, 1: FSM is not in IDLE.

## Operation

- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, TRAP_JUMP, MRET_STATUS, MRET_JUMP.
- Instruction decode (exact 32-bit match):
  - ecall 0x00000073, mcause 11.
  - ebreak 0x00100073, mcause 3.
  - mret 0x30200073.
- Async pending vector: int_req_i & int_mask_i & {INT_NUM{mstatus[3]}}. The winner is the lowest set index k. Its mcause is {1'b1, (DATA_W-1)'(16+k)}.
- IDLE priority: sync exception first, then mret, then async interrupt.
- On accepting an event, the FSM captures cause and epc:
  - Sync: epc = inst_addr_i.
  - Async: epc = jump_addr_i if jump_flag_i is high, else inst_addr_i.
- Trap path: IDLE -> SAVE_EPC -> SAVE_CAUSE -> SAVE_STATUS -> TRAP_JUMP -> IDLE.
  - SAVE_EPC: wen=1, waddr=0x341, wdata=epc.
  - SAVE_CAUSE: wen=1, waddr=0x342, wdata=cause.
  - SAVE_STATUS: wen=1, waddr=0x300, wdata = mstatus with bit7 ← bit3 (MPIE ← MIE) and bit3 ← 0. All other bits pass through.
  - TRAP_JUMP: int_flag_o=1.
    - int_addr_o = {mtvec[DATA_W-1:2], 2'b00} (direct mode).
    - Exception: when mtvec[1:0]==2'b01 and the cause is async, int_addr_o = that base + 4*(16+k) (vectored mode).
- Mret path: IDLE -> MRET_STATUS -> MRET_JUMP -> IDLE.
  - MRET_STATUS: wen=1, waddr=0x300, wdata = mstatus with bit3 ← bit7 and bit7 ← 1.
  - MRET_JUMP: int_flag_o=1, int_addr_o=csr_mepc_i.
- Events that arrive while busy_o=1 are not accepted. The sync instruction is frozen by the hold. An async line that is still asserted is re-evaluated in IDLE.

## Timing

- Reset values: FSM in IDLE; every output 0; captured epc and cause cleared.
- hold_flag_o:
  - Combinational 1 in the IDLE cycle that accepts an event.
  - Held at 1 in every non-IDLE state.
  - Returns to 0 in the cycle after the jump state.
- Trap latency: event accepted at cycle N. CSR writes at N+1, N+2, N+3. int_flag_o at N+4. busy_o falls at N+5.
- Mret latency: mret at N. mstatus write at N+1. int_flag_o at N+2.
- clint_wen_o is high for exactly one cycle per write state. clint_waddr_o and clint_wdata_o are 0 whenever wen=0.
- csr_mstatus_i and csr_mtvec_i are sampled in the state that uses them. csr_reg must make a write visible by the next cycle.
- Simultaneous ecall and async interrupt: ecall is taken. The interrupt stays pending, but MIE=0 after the save, so it is taken only after mret.
- An interrupt line deasserted before it is accepted is lost; there is no edge latch.
- Reset asserted mid-sequence returns the FSM to IDLE immediately with all outputs 0. Partial CSR writes are not undone.

## Test plan

- Reset check: hold rst_n_i low, drive int_req_i=8'hFF and ecall -> all outputs 0. One cycle after release with mstatus=0x8 -> the trap sequence starts for cause 0x80000010.
- ecall at inst_addr_i=0x100 with mtvec=0x200 -> writes (0x341,0x100), (0x342,11), (0x300, mstatus 0x8→0x80) -> int_flag_o with int_addr_o=0x200 at N+4.
- Async arbitration: int_req_i=8'b0000_1100, mask=8'hFF, MIE=1, mtvec=0x201, jump_flag_i=1, jump_addr_i=0x400 -> mepc=0x400, mcause=0x80000012, int_addr_o=0x200+0x48=0x248.
- Masking: int_req_i=8'h01 with int_mask_i=0, or with MIE=0 -> no write, hold_flag_o stays 0.
- mret with mepc=0x104, mstatus=0x80 -> write (0x300, 0x88) at N+1 -> int_flag_o with int_addr_o=0x104 at N+2.
- Reset mid-trap: pulse rst_n_i low during SAVE_CAUSE -> all outputs 0 asynchronously. A later ebreak produces a full, clean sequence with cause 3.
